alu_cmd_issuer: RTL

Command-side sequencer for the team's 4-bit combinational ALU (op 00 = arithmetic shift right A by SH, 01 = logical shift right A by SH, 10 = A−B mod 16, 11 = A+B mod 16). It accepts packed commands over a valid/ready handshake and drives registered operands onto the ALU ports. After a fixed settle interval it samples the ALU answer and returns it over a second valid/ready handshake. A chain bit lets a command use the previous result as operand A, so multi-step arithmetic runs without a round trip to the host.

---
 rtl/alu_cmd_issuer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/alu_cmd_issuer.sv
// Command sequencer for the 4-bit combinational ALU: registers operands,
// waits SETTLE edges, captures alu_ans and returns it over a valid/ready port.
module alu_cmd_issuer #(
   parameter int unsigned SETTLE = 1
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [12:0] cmd_data_i,
   output logic [3:0]  alu_a_o,
   output logic [3:0]  alu_b_o,
   output logic [1:0]  alu_op_o,
   output logic [1:0]  alu_sh_o,
   input  logic [3:0]  alu_ans_i,
   output logic        res_valid_o,
   input  logic        res_ready_i,
   output logic [3:0]  res_data_o,
   output logic [1:0]  res_tag_o,
   output logic        busy_o,
   output logic [7:0]  cmd_count_o
);

   localparam logic [2:0] SETTLE_C = 3'(SETTLE);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_e;

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [3:0]  acc_q, acc_d;
   logic [1:0]  tag_q, tag_d;
   logic [3:0]  res_data_q, res_data_d;
   logic [1:0]  res_tag_q, res_tag_d;
   logic        res_valid_q, res_valid_d;
   logic [3:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [1:0]  alu_op_q, alu_op_d, alu_sh_q, alu_sh_d;
   logic [7:0]  cmd_count_q, cmd_count_d;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         tag_q       <= '0;
         res_data_q  <= '0;
         res_tag_q   <= '0;
         res_valid_q <= 1'b0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= '0;
         alu_sh_q    <= '0;
         cmd_count_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         tag_q       <= tag_d;
         res_data_q  <= res_data_d;
         res_tag_q   <= res_tag_d;
         res_valid_q <= res_valid_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         alu_sh_q    <= alu_sh_d;
         cmd_count_q <= cmd_count_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      tag_d       = tag_q;
      res_data_d  = res_data_q;
      res_tag_d   = res_tag_q;
      res_valid_d = res_valid_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      alu_sh_d    = alu_sh_q;
      cmd_count_d = cmd_count_q;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid_i) begin
               // chain bit substitutes the last captured result for operand A
               alu_a_d     = cmd_data_i[12] ? acc_q : cmd_data_i[7:4];
               alu_b_d     = cmd_data_i[3:0];
               alu_op_d    = cmd_data_i[11:10];
               alu_sh_d    = cmd_data_i[9:8];
               cnt_d       = SETTLE_C;
               cmd_count_d = cmd_count_q + 8'd1;
               state_d     = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (cnt_q == 3'd1) begin
               res_data_d  = alu_ans_i;
               acc_d       = alu_ans_i;
               res_tag_d   = tag_q;
               res_valid_d = 1'b1;
               state_d     = S_HOLD;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         S_HOLD: begin
            if (res_ready_i) begin
               res_valid_d = 1'b0;
               tag_d       = tag_q + 2'd1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign cmd_ready_o = (state_q == S_IDLE);
   assign busy_o      = (state_q != S_IDLE);
   assign alu_a_o     = alu_a_q;
   assign alu_b_o     = alu_b_q;
   assign alu_op_o    = alu_op_q;
   assign alu_sh_o    = alu_sh_q;
   assign res_valid_o = res_valid_q;
   assign res_data_o  = res_data_q;
   assign res_tag_o   = res_tag_q;
   assign cmd_count_o = cmd_count_q;

endmodule
